// File: rtl/pixel_stream_pkg.sv
// rtl/pixel_stream_pkg.sv - shared types, defaults and helpers for the pixel stream packer
//
// Purpose: FSM state encoding, default sizing parameters and the byte
// inversion helper used by pixel_stream_packer and its sub-module.
package pixel_stream_pkg;

  localparam int MAX_CHANNEL_DEF = 4;
  localparam int DIM_W_DEF       = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic [7:0] pxl_invert(input logic [7:0] b);
    return 8'hFF - b;
  endfunction

endpackage

// File: rtl/pixel_frame_counter.sv
// rtl/pixel_frame_counter.sv - column/row position tracker with frame marker decode
//
// Purpose: tracks the position of the pixel currently being assembled and
// decodes its start-of-frame / end-of-line / end-of-frame markers.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   clear          return to column 0, row 0
//   step           advance one pixel (column wraps at width-1, row increments)
//   width, height  frame geometry of the current frame
//   sof, eol, eof  markers for the current position
module pixel_frame_counter #(
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             step,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  output logic             sof,
  output logic             eol,
  output logic             eof
);

  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] row_q, row_d;

  assign sof = (col_q == '0) && (row_q == '0);
  assign eol = (col_q == width - 1'b1);
  assign eof = eol && (row_q == height - 1'b1);

  // Row never wraps: the frame ends at eof and the next frame starts with clear.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (step) begin
      if (eol) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/pixel_stream_packer.sv
// rtl/pixel_stream_packer.sv - packs a frame byte stream into one word per pixel with frame markers
//
// Purpose: accepts frame bytes (line, pixel, channel order), optionally
// inverts them, packs the channel bytes of each pixel into one word and
// emits it with sof/eol/eof markers under valid/ready flow control.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   cfg_width/height/channel/invert   frame configuration, sampled at accepted start
//   start, busy, done, err_cfg        frame control and status
//   s_valid, s_ready, s_data          byte input stream
//   m_valid, m_ready, m_data          packed pixel output stream
//   m_sof, m_eol, m_eof               frame markers qualified by m_valid
module pixel_stream_packer
  import pixel_stream_pkg::*;
#(
  parameter int MAX_CHANNEL = MAX_CHANNEL_DEF,
  parameter int DIM_W       = DIM_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DIM_W-1:0]         cfg_width,
  input  logic [DIM_W-1:0]         cfg_height,
  input  logic [2:0]               cfg_channel,
  input  logic                     cfg_invert,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err_cfg,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [7:0]               s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [8*MAX_CHANNEL-1:0] m_data,
  output logic                     m_sof,
  output logic                     m_eol,
  output logic                     m_eof
);

  localparam logic [2:0] MAX_CH3 = 3'(MAX_CHANNEL);

  state_e                   state_q, state_d;
  logic [DIM_W-1:0]         width_q, width_d;
  logic [DIM_W-1:0]         height_q, height_d;
  logic [2:0]               channel_q, channel_d;
  logic                     invert_q, invert_d;
  logic [2:0]               byte_idx_q, byte_idx_d;
  logic [8*MAX_CHANNEL-1:0] asm_q, asm_d;
  logic [8*MAX_CHANNEL-1:0] m_data_q, m_data_d;
  logic                     m_valid_q, m_valid_d;
  logic                     m_sof_q, m_sof_d;
  logic                     m_eol_q, m_eol_d;
  logic                     m_eof_q, m_eof_d;
  logic                     done_q, done_d;
  logic                     err_cfg_q, err_cfg_d;

  logic       last_byte, s_fire, pix_fire, m_fire, cfg_ok, start_ok;
  logic       f_sof, f_eol, f_eof;
  logic [7:0] byte_in;

  assign last_byte = (byte_idx_q == channel_q - 3'd1);
  // The final byte of a pixel needs room in the output register; earlier
  // bytes only go into the assembly register and can always be taken.
  assign s_ready   = (state_q == ST_RUN) && (!last_byte || !m_valid_q || m_ready);
  assign s_fire    = s_valid && s_ready;
  assign pix_fire  = s_fire && last_byte;
  assign m_fire    = m_valid_q && m_ready;
  assign cfg_ok    = (cfg_width != '0) && (cfg_height != '0) &&
                     (cfg_channel != 3'd0) && (cfg_channel <= MAX_CH3);
  assign start_ok  = (state_q == ST_IDLE) && start && cfg_ok;
  assign byte_in   = invert_q ? pxl_invert(s_data) : s_data;

  pixel_frame_counter #(.DIM_W(DIM_W)) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (start_ok),
    .step    (pix_fire),
    .width   (width_q),
    .height  (height_q),
    .sof     (f_sof),
    .eol     (f_eol),
    .eof     (f_eof)
  );

  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    height_d   = height_q;
    channel_d  = channel_q;
    invert_d   = invert_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_sof_d    = m_sof_q;
    m_eol_d    = m_eol_q;
    m_eof_d    = m_eof_q;
    done_d     = 1'b0;
    err_cfg_d  = 1'b0;

    if (m_fire) begin
      m_valid_d = 1'b0;
    end

    // Byte 0 of each pixel starts from a zeroed word so unused upper bytes read 0.
    if (s_fire) begin
      if (byte_idx_q == 3'd0) begin
        asm_d = '0;
      end
      for (int k = 0; k < MAX_CHANNEL; k++) begin
        if (byte_idx_q == 3'(k)) begin
          asm_d[8*k +: 8] = byte_in;
        end
      end
      byte_idx_d = last_byte ? 3'd0 : byte_idx_q + 3'd1;
    end

    if (pix_fire) begin
      m_data_d  = asm_d;
      m_valid_d = 1'b1;
      m_sof_d   = f_sof;
      m_eol_d   = f_eol;
      m_eof_d   = f_eof;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            width_d    = cfg_width;
            height_d   = cfg_height;
            channel_d  = cfg_channel;
            invert_d   = cfg_invert;
            byte_idx_d = 3'd0;
            asm_d      = '0;
            state_d    = ST_RUN;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (pix_fire && f_eof) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (m_fire && m_eof_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      width_q    <= '0;
      height_q   <= '0;
      channel_q  <= 3'd0;
      invert_q   <= 1'b0;
      byte_idx_q <= 3'd0;
      asm_q      <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_sof_q    <= 1'b0;
      m_eol_q    <= 1'b0;
      m_eof_q    <= 1'b0;
      done_q     <= 1'b0;
      err_cfg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      height_q   <= height_d;
      channel_q  <= channel_d;
      invert_q   <= invert_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_sof_q    <= m_sof_d;
      m_eol_q    <= m_eol_d;
      m_eof_q    <= m_eof_d;
      done_q     <= done_d;
      err_cfg_q  <= err_cfg_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign err_cfg = err_cfg_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_sof   = m_sof_q;
  assign m_eol   = m_eol_q;
  assign m_eof   = m_eof_q;

endmodule

// File: doc/pixel_stream_packer.md
# pixel_stream_packer

Streaming front-end for the BMP image path: accepts the raw byte stream of a frame (the same byte order the DPI bitmap reader returns: line by line, pixel by pixel, channel by channel), optionally inverts each byte (255-x), packs the channel bytes of one pixel into a single word, and emits it with start-of-frame, end-of-line and end-of-frame markers under valid/ready flow control. It sits between the DPI-driven test harness, which feeds bytes, and the downstream pixel-processing datapath, which consumes pixels.

## Interface
- MAX_CHANNEL, 4, maximum bytes per pixel; output word is 8*MAX_CHANNEL bits
- DIM_W, 16, width of the frame width/height fields and counters

- clk  input  1  sole clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- cfg_width  input  DIM_W  pixels per line, sampled at accepted start
- cfg_height  input  DIM_W  lines per frame, sampled at accepted start
- cfg_channel  input  3  bytes per pixel (1..MAX_CHANNEL), sampled at accepted start
- cfg_invert  input  1  1: each byte replaced by 8'hFF - byte; sampled at accepted start
- start  input  1  single-cycle frame start request
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse when the last pixel is accepted downstream
- err_cfg  output  1  one-cycle pulse when start is rejected for bad configuration
- s_valid  input  1  byte valid
- s_ready  output  1  byte accepted when s_valid && s_ready
- s_data  input  8  pixel byte
- m_valid  output  1  pixel valid
- m_ready  input  1  pixel accepted when m_valid && m_ready
- m_data  output  8*MAX_CHANNEL  packed pixel; byte k at [8k+7:8k]; unused bytes zero
- m_sof  output  1  first pixel of frame (col 0, row 0)
- m_eol  output  1  last pixel of a line (col = width-1)
- m_eof  output  1  last pixel of frame (m_eol && row = height-1)

## Operation
- FSM: IDLE, RUN, DRAIN.
- IDLE: start with width≠0, height≠0, 1≤channel≤MAX_CHANNEL -> latch cfg, clear counters, go RUN, busy=1 next cycle. Bad cfg -> err_cfg pulse next cycle, stay IDLE. start in RUN/DRAIN ignored.
- RUN: bytes accepted into assembly register at index byte_idx; byte_idx wraps at channel-1. On the final byte of a pixel, the assembled word (with that byte) is loaded into the output register with sof/eol/eof computed from col/row.
- col increments per pixel, wraps to 0 at width-1 with row increment; row never wraps.
- After the final byte of the frame's last pixel is accepted -> DRAIN; s_ready=0.
- DRAIN: when the eof pixel handshakes -> done pulse, busy=0, IDLE.
- Bytes offered in IDLE/DRAIN are not accepted (s_ready=0).
- Assembly register cleared at each pixel start so unused upper bytes read zero.

## Timing
- Reset values: busy, done, err_cfg, s_ready, m_valid, m_sof, m_eol, m_eof = 0; m_data = 0; FSM = IDLE; all counters 0.
- s_ready in RUN = (byte_idx ≠ channel-1) || !m_valid || m_ready; combinational from m_ready allowed.
- Latency: m_valid rises the cycle after the final byte of a pixel is accepted.
- Throughput: 1 byte/clk sustained with m_ready held high; no bubble between pixels.
- m_valid/m_data/flags hold stable while m_valid && !m_ready.
- channel=1: every accepted byte produces a pixel; s_ready = !m_valid || m_ready.
- Reset asserted mid-frame: all state cleared immediately; partial pixel discarded; no done.
- start and reset_n low together: reset wins.

## Structure
- Package pixel_stream_pkg: state enum (IDLE/RUN/DRAIN), MAX_CHANNEL default, DIM_W default, function pxl_invert(byte) = 8'hFF - byte.
- Sub-module pixel_frame_counter: col/row counters with sof/eol/eof decode, inputs width/height/step/clear.
- Top: FSM, byte assembly, output register, handshake logic.

## Test plan
- 2x2, channel=3, invert=0, bytes 0x01..0x0C, m_ready=1 -> 4 pixels 0x030201, 0x060504, 0x090807, 0x0C0B0A; sof on pixel 0, eol on pixels 1 and 3, eof on pixel 3; done 1 cycle after last handshake.
- Same frame, invert=1 -> pixels 0xFCFDFE, 0xF9FAFB, 0xF6F7F8, 0xF3F4F5; upper byte 0x00.
- 3x1, channel=1, m_ready toggling 1-0-1 -> output held stable when stalled, 3 pixels in order, no byte lost or duplicated, eol/eof on pixel 2.
- start with width=0, then channel=5 -> err_cfg pulse each, busy stays 0, s_ready stays 0.
- start pulsed again during RUN of a 4x4 channel=4 frame -> ignored; exactly 16 pixels, one done.
- reset_n low after 5 bytes of a 2x2 channel=3 frame -> all outputs 0 immediately; new start runs a clean frame from sof.
